// File: rtl/apb_pkg.sv
// Shared APB master types, width defaults and the round-robin index helper.
// Pure declarations: no latency, no flow control.
// Holds nothing stateful.
package apb_pkg;

    localparam int DEF_ADDR_SIZE = 10;
    localparam int DEF_DATA_SIZE = 32;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    // (base + off) mod n for base, off in [0, n); avoids a general divider.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick: first eligible requester at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o=0 when nothing is eligible.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               found_o
);

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible_i[IDX_W'(rr_wrap(int'(ptr_i), k, NUM_REQ))]) begin
                grant_o = IDX_W'(rr_wrap(int'(ptr_i), k, NUM_REQ));
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave port between NUM_REQ requesters, round-robin; APB_TIMEOUT_EN adds an ACCESS abort.
// Latency: req_valid@T0 -> psel@T1 -> penable@T2 -> rsp_valid@T3, +1 per pready wait cycle.
// Backpressure: requesters hold req_valid until their rsp_valid pulse; pready stalls ACCESS.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
    parameter int DATA_SIZE      = DEF_DATA_SIZE,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_SIZE-1:0]           rsp_rdata,
    output logic                           rsp_err,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [ADDR_SIZE-1:0]           paddr,
    output logic [DATA_SIZE-1:0]           pwdata,
    input  logic                           pready,
    input  logic [DATA_SIZE-1:0]           prdata,
    input  logic                           pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    apb_state_t             state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       grant_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [ADDR_SIZE-1:0]   paddr_q;
    logic [DATA_SIZE-1:0]   pwdata_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DATA_SIZE-1:0]   rsp_rdata_q;
    logic                   rsp_err_q;

    logic [NUM_REQ-1:0]     eligible;
    logic [IDX_W-1:0]       arb_grant;
    logic                   arb_found;

`ifdef APB_TIMEOUT_EN
    logic [7:0]             wait_q;
    logic                   timeout;
    assign timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));
`endif

    // A requester whose completion pulse is on the wire this cycle is still
    // holding req_valid from the old transfer; it must not be re-granted.
    assign eligible = req_valid & ~rsp_valid_q;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (arb_grant),
        .found_o    (arb_found)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= APB_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                APB_IDLE: begin
                    if (arb_found) begin
                        grant_q   <= arb_grant;
                        ptr_q     <= IDX_W'(rr_wrap(int'(arb_grant), 1, NUM_REQ));
                        paddr_q   <= req_addr[int'(arb_grant) * ADDR_SIZE +: ADDR_SIZE];
                        pwdata_q  <= req_wdata[int'(arb_grant) * DATA_SIZE +: DATA_SIZE];
                        pwrite_q  <= req_write[arb_grant];
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= APB_SETUP;
`ifdef APB_TIMEOUT_EN
                        wait_q    <= '0;
`endif
                    end
                end
                APB_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (pready) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        state_q              <= APB_IDLE;
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= pslverr;
                        rsp_rdata_q          <= pwrite_q ? '0 : prdata;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (timeout) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        state_q              <= APB_IDLE;
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_rdata_q          <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
`endif
                end
                default: state_q <= APB_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
